// File: rtl/program_loader.sv
// Boot-stage image loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the image is complete.
module program_loader #(
   parameter int MAX_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] base_address,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_reset,
   output logic [31:0] initial_address,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_data is only
   // looked at on such an edge, and rx_ready never depends on rx_valid.

   typedef enum logic [1:0] {
      S_LEN  = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] MAX_LEN   = 32'(MAX_WORDS);
   localparam bit          TMO_ON    = (TIMEOUT_CYCLES != 0);

   state_t      state_q, state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] asm_q, asm_d;
   logic [15:0] len_q, len_d;
   logic [31:0] tmo_q, tmo_d;
   logic        imem_we_q, imem_we_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic        core_reset_q, core_reset_d;
   logic [31:0] initial_address_q, initial_address_d;
   logic        load_done_q, load_done_d;
   logic        load_error_q, load_error_d;
   logic [15:0] words_loaded_q, words_loaded_d;

   logic        xfer;
   logic        last_byte;
   logic [31:0] asm_word;
   logic        tmo_active;
   logic        tmo_hit;

   // Reset is folded in so a byte offered during reset is never accepted.
   assign rx_ready  = ~reset & ((state_q == S_LEN) | (state_q == S_DATA));
   assign xfer      = rx_valid & rx_ready;
   assign last_byte = xfer & (byte_idx_q == 2'd3);
   assign asm_word  = {rx_data, asm_q};

   always_comb begin
      state_d           = state_q;
      byte_idx_d        = byte_idx_q;
      asm_d             = asm_q;
      len_d             = len_q;
      tmo_d             = tmo_q;
      imem_we_d         = 1'b0;
      imem_addr_d       = imem_addr_q;
      imem_wdata_d      = imem_wdata_q;
      core_reset_d      = core_reset_q;
      initial_address_d = initial_address_q;
      load_done_d       = load_done_q;
      load_error_d      = load_error_q;
      words_loaded_d    = words_loaded_q;
      tmo_hit           = 1'b0;

      // An empty S_LEN is waiting for a sender that may never have started.
      tmo_active = (state_q == S_DATA) | ((state_q == S_LEN) & (byte_idx_q != 2'd0));

      if (xfer) begin
         byte_idx_d = byte_idx_q + 2'd1;
         tmo_d      = 32'd0;
         case (byte_idx_q)
            2'd0:    asm_d[7:0]   = rx_data;
            2'd1:    asm_d[15:8]  = rx_data;
            2'd2:    asm_d[23:16] = rx_data;
            default: asm_d        = asm_q;
         endcase
      end else if (tmo_active) begin
         tmo_d   = tmo_q + 32'd1;
         tmo_hit = TMO_ON && (tmo_d == TMO_LIMIT);
      end

      case (state_q)
         S_LEN: begin
            if (xfer && (byte_idx_q == 2'd0)) begin
               initial_address_d = {base_address[31:2], 2'b00};
            end
            if (last_byte) begin
               if ((asm_word == 32'd0) || (asm_word > MAX_LEN)) begin
                  state_d      = S_ERR;
                  load_error_d = 1'b1;
                  core_reset_d = 1'b1;
               end else begin
                  state_d = S_DATA;
                  len_d   = asm_word[15:0];
               end
            end else if (tmo_hit) begin
               state_d      = S_ERR;
               load_error_d = 1'b1;
               core_reset_d = 1'b1;
            end
         end
         S_DATA: begin
            if (last_byte) begin
               imem_we_d      = 1'b1;
               imem_addr_d    = initial_address_q + {14'd0, words_loaded_q, 2'b00};
               imem_wdata_d   = asm_word;
               words_loaded_d = words_loaded_q + 16'd1;
               if (words_loaded_d == len_q) begin
                  state_d     = S_DONE;
                  load_done_d = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d      = S_ERR;
               load_error_d = 1'b1;
               core_reset_d = 1'b1;
            end
         end
         S_DONE: begin
            // Released one cycle after entry so the final write lands with the core still held.
            core_reset_d = 1'b0;
         end
         default: begin
            core_reset_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= S_LEN;
         byte_idx_q        <= 2'd0;
         asm_q             <= 24'd0;
         len_q             <= 16'd0;
         tmo_q             <= 32'd0;
         imem_we_q         <= 1'b0;
         imem_addr_q       <= 32'd0;
         imem_wdata_q      <= 32'd0;
         core_reset_q      <= 1'b1;
         initial_address_q <= 32'd0;
         load_done_q       <= 1'b0;
         load_error_q      <= 1'b0;
         words_loaded_q    <= 16'd0;
      end else begin
         state_q           <= state_d;
         byte_idx_q        <= byte_idx_d;
         asm_q             <= asm_d;
         len_q             <= len_d;
         tmo_q             <= tmo_d;
         imem_we_q         <= imem_we_d;
         imem_addr_q       <= imem_addr_d;
         imem_wdata_q      <= imem_wdata_d;
         core_reset_q      <= core_reset_d;
         initial_address_q <= initial_address_d;
         load_done_q       <= load_done_d;
         load_error_q      <= load_error_d;
         words_loaded_q    <= words_loaded_d;
      end
   end

   assign imem_we         = imem_we_q;
   assign imem_addr       = imem_addr_q;
   assign imem_wdata      = imem_wdata_q;
   assign core_reset      = core_reset_q;
   assign initial_address = initial_address_q;
   assign load_done       = load_done_q;
   assign load_error      = load_error_q;
   assign words_loaded    = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed boot scenarios plus randomized images, checked by a
// write scoreboard fed from an image-level reference model.
module tb_program_loader;

   localparam int MAX_WORDS = 256;
   localparam int TO        = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] base_address;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic [31:0] initial_address;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_loaded;

   program_loader #(
      .MAX_WORDS      (MAX_WORDS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .base_address    (base_address),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .imem_we         (imem_we),
      .imem_addr       (imem_addr),
      .imem_wdata      (imem_wdata),
      .core_reset      (core_reset),
      .initial_address (initial_address),
      .load_done       (load_done),
      .load_error      (load_error),
      .words_loaded    (words_loaded)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // {expected words_loaded, expected address, expected data}
   logic [79:0] exp_q[$];
   logic [7:0]  img_q[$];
   int          gap_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   logic        prev_we = 1'b0;
   logic [79:0] mon_e;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         check("we_single_cycle", {31'd0, prev_we}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", imem_addr, mon_e[63:32]);
            check("write_data", imem_wdata, mon_e[31:0]);
            check("write_count", {16'd0, words_loaded}, {16'd0, mon_e[79:64]});
         end
      end
      prev_we = imem_we;
   end

   // Drivers
   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited   = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (rx_ready === 1'b1) break;
         waited++;
         if (waited > 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: rx_ready low for %0d cycles, expected 1", waited);
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/rx_ready"}, {31'd0, rx_ready}, 32'd0);
      check({tag, "/imem_we"}, {31'd0, imem_we}, 32'd0);
      check({tag, "/imem_addr"}, imem_addr, 32'd0);
      check({tag, "/imem_wdata"}, imem_wdata, 32'd0);
      check({tag, "/core_reset"}, {31'd0, core_reset}, 32'd1);
      check({tag, "/initial_address"}, initial_address, 32'd0);
      check({tag, "/load_done"}, {31'd0, load_done}, 32'd0);
      check({tag, "/load_error"}, {31'd0, load_error}, 32'd0);
      check({tag, "/words_loaded"}, {16'd0, words_loaded}, 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Image built from packed bytes, first byte in the least significant position.
   task automatic set_image(input int n, input logic [255:0] bytes);
      img_q.delete();
      gap_q.delete();
      for (int i = 0; i < n; i++) begin
         img_q.push_back(bytes[8*i +: 8]);
         gap_q.push_back(0);
      end
   endtask

   task automatic build_random(input logic [31:0] len, input int nwords);
      img_q.delete();
      gap_q.delete();
      for (int b = 0; b < 4; b++) img_q.push_back(len[8*b +: 8]);
      for (int b = 0; b < 4 * nwords; b++) img_q.push_back(8'($urandom));
      for (int b = 0; b < img_q.size(); b++) gap_q.push_back(0);
   endtask

   // Reference model: decides from the image as a whole which words get written and how
   // the load ends, then drives the bytes and checks the outcome.
   task automatic run_image(input logic [31:0] base, input string tag);
      logic [31:0] len;
      logic [31:0] start;
      bit          len_ok;
      bit          timed_out;
      bit          done;
      int          needed;
      int          stop;
      int          n_wr;

      start     = base & 32'hFFFF_FFFC;
      len       = {img_q[3], img_q[2], img_q[1], img_q[0]};
      len_ok    = (len >= 32'd1) && (len <= 32'(MAX_WORDS));
      needed    = len_ok ? 4 + 4 * int'(len) : 4;
      stop      = needed;
      timed_out = 1'b0;
      for (int j = 1; j < needed; j++) begin
         if (gap_q[j] >= TO) begin
            stop      = j;
            timed_out = 1'b1;
            break;
         end
      end
      done = len_ok && !timed_out;
      n_wr = 0;
      for (int i = 0; len_ok && (4 + 4 * i + 3 < stop); i++) begin
         exp_q.push_back({16'(i + 1), start + 32'(4 * i),
                          img_q[4*i+7], img_q[4*i+6], img_q[4*i+5], img_q[4*i+4]});
         n_wr++;
      end

      base_address = base;
      for (int j = 0; j < stop; j++) begin
         idle(gap_q[j]);
         send_byte(img_q[j]);
      end

      if (timed_out) begin
         idle(TO - 1);
         check({tag, "/no_error_before_timeout"}, {31'd0, load_error}, 32'd0);
         idle(1);
         check({tag, "/timeout_error"}, {31'd0, load_error}, 32'd1);
      end else if (done) begin
         check({tag, "/done_on_last_edge"}, {31'd0, load_done}, 32'd1);
         check({tag, "/core_held_at_last_write"}, {31'd0, core_reset}, 32'd1);
         check({tag, "/last_write_strobe"}, {31'd0, imem_we}, 32'd1);
         idle(1);
         check({tag, "/core_released"}, {31'd0, core_reset}, 32'd0);
      end else begin
         check({tag, "/length_error"}, {31'd0, load_error}, 32'd1);
      end

      idle(3);
      check({tag, "/writes_drained"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check({tag, "/words_loaded"}, {16'd0, words_loaded}, 32'(n_wr));
      check({tag, "/initial_address"}, initial_address, start);
      check({tag, "/rx_ready_end"}, {31'd0, rx_ready}, 32'd0);
      check({tag, "/load_done"}, {31'd0, load_done}, {31'd0, done});
      check({tag, "/load_error"}, {31'd0, load_error}, {31'd0, !done});
      check({tag, "/core_reset"}, {31'd0, core_reset}, {31'd0, !done});
   endtask

   task automatic random_case(input int iter);
      int          mode;
      int          n;
      int          j;
      logic [31:0] len;
      mode = $urandom_range(0, 5);
      n    = $urandom_range(1, 5);
      if (mode == 0) begin
         case ($urandom_range(0, 2))
            0:       len = 32'd0;
            1:       len = 32'(257 + $urandom_range(0, 1000));
            default: len = {8'($urandom_range(1, 255)), 24'($urandom)};
         endcase
      end else begin
         len = 32'(n);
      end
      build_random(len, n);
      for (int b = 0; b < gap_q.size(); b++) begin
         gap_q[b] = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      end
      if (mode == 1) begin
         j        = $urandom_range(1, 4 + 4 * n - 1);
         gap_q[j] = TO + int'($urandom_range(0, 4));
      end
      do_reset();
      run_image($urandom, $sformatf("rand%0d", iter));
   endtask

   // Stimulus
   initial begin
      reset        = 1'b1;
      rx_valid     = 1'b0;
      rx_data      = 8'd0;
      base_address = 32'd0;
      @(posedge clk);
      #1;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      set_image(12, 256'h00b00593_00a00513_00000002);
      run_image(32'h0, "t1_two_words");

      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t6_rx_ready_after_done", {31'd0, rx_ready}, 32'd0);
      end
      rx_valid = 1'b0;
      check("t6_words_loaded", {16'd0, words_loaded}, 32'd2);
      check("t6_load_done", {31'd0, load_done}, 32'd1);

      do_reset();
      set_image(8, 256'hdeadbeef_00000001);
      run_image(32'h103, "t2_unaligned_base");

      do_reset();
      set_image(4, 256'h0);
      run_image(32'h80, "t3_len_zero");

      do_reset();
      set_image(4, 256'h00000101);
      run_image(32'h80, "t3_len_257");

      do_reset();
      build_random(32'(MAX_WORDS), MAX_WORDS);
      run_image(32'hFFFF_FF00, "t3_len_max_wrap");

      do_reset();
      set_image(8, 256'h12345678_00000001);
      gap_q[6] = TO - 1;
      run_image(32'h20, "t4_gap_15");

      do_reset();
      set_image(8, 256'h12345678_00000001);
      gap_q[6] = TO;
      run_image(32'h20, "t4_gap_16");

      do_reset();
      set_image(8, 256'hcafef00d_00000001);
      gap_q[0] = 3 * TO;
      run_image(32'h24, "t4_idle_before_first");

      do_reset();
      base_address = 32'h200;
      set_image(6, 256'hbbaa_00000002);
      for (int j = 0; j < 6; j++) send_byte(img_q[j]);
      reset    = 1'b1;
      rx_data  = 8'hFF;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("t5_mid_reset");
      @(posedge clk);
      #1;
      reset    = 1'b0;
      rx_valid = 1'b0;
      set_image(8, 256'h0badc0de_00000001);
      run_image(32'h40, "t5_reload");

      for (int it = 0; it < 25; it++) random_case(it);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream boot stage for the monocycle RISC-V core. It receives a program image as a byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words into the instruction memory write port and holds the core in reset until the image is complete. It then releases core reset and presents the start address to the core's initial_address input.

Parameters:
MAX_WORDS, 256, largest accepted image length in 32-bit words (1..65535)
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes once a load has started; 0 disables the timeout

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
base_address  input  32  byte address where word 0 is written; bits [1:0] ignored (forced 0)
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte; a byte transfers on an edge where rx_valid && rx_ready
imem_we  output  1  instruction memory write strobe, single-cycle pulse
imem_addr  output  32  instruction memory byte address
imem_wdata  output  32  instruction word to write
core_reset  output  1  reset to the core, active-high
initial_address  output  32  start address for the core (latched base, word-aligned)
load_done  output  1  image loaded; core released
load_error  output  1  load aborted; core held in reset
words_loaded  output  16  count of words written so far

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values (edge with reset=1):
  - state=S_LEN; rx_ready=0; imem_we=0; imem_addr=0; imem_wdata=0.
  - core_reset=1; initial_address=0; load_done=0; load_error=0; words_loaded=0.
  - Byte, word and timeout counters are cleared.
  - Instruction memory contents are not touched.
- rx_ready=1 in S_LEN and S_DATA when reset is low; 0 in S_DONE and S_ERR.
- Byte assembly: a 2-bit byte index counts accepted bytes and wraps 3->0. Byte k lands in bits [8k+7:8k].
- S_LEN:
  - The first 4 accepted bytes form the length N.
  - When the first length byte is accepted, base_address & ~3 is latched into initial_address.
  - On the edge accepting the 4th byte: if N==0 or N>MAX_WORDS, go to S_ERR; otherwise go to S_DATA.
- S_DATA:
  - On the edge accepting the 4th byte of word i, the following are registered: imem_we<=1, imem_addr<=initial_address+4*i (32-bit wrap), imem_wdata<=assembled word, words_loaded<=i+1.
  - imem_we is 1 for exactly that one following cycle. Back-to-back words give writes at most every 4th cycle.
  - If i+1==N, go to S_DONE on the same edge.
- S_DONE:
  - load_done=1 from entry onward.
  - core_reset drops to 0 one cycle after entry, so the final imem write completes while the core is still in reset.
  - Stays in S_DONE until reset; further rx bytes are not accepted.
- S_ERR: load_error=1, core_reset=1, imem_we=0, rx_ready=0. Stays in S_ERR until reset.
- Timeout:
  - Counter is active in S_LEN (after at least one byte accepted) and in S_DATA.
  - It increments each cycle with no transfer and clears to 0 on a transfer.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to S_ERR on that edge. A gap of TIMEOUT_CYCLES-1 idle cycles is tolerated; a gap of TIMEOUT_CYCLES idle cycles errors.
  - S_LEN with zero bytes received never times out.
- Reset mid-load or after done: returns to the reset state and re-asserts core_reset; already-written memory words are left as is.
- Simultaneous reset and rx_valid: reset wins and the byte is not accepted.

Test Plan:
1. base=0; send 02 00 00 00 13 05 a0 00 93 05 b0 00 back-to-back -> imem writes 0x00a00513@0x0 then 0x00b00593@0x4, words_loaded=2, load_done=1, core_reset falls exactly 1 cycle after the last imem_we, initial_address=0.
2. base=0x103, N=1, word EF BE AD DE -> single write 0xDEADBEEF@0x100, initial_address=0x100.
3. Length 00 00 00 00 -> load_error=1 on the 4th-byte edge, no imem_we ever, rx_ready=0, core_reset stays 1; a repeat with N=257 (MAX_WORDS=256) gives the same result.
4. TIMEOUT_CYCLES=16, N=1: a mid-word gap of 15 idle cycles -> load completes normally; a gap of 16 idle cycles -> load_error=1, no write.
5. Assert reset after 2 data bytes of a 2-word image -> outputs return to reset values; a fresh 1-word image at base 0x40 then loads correctly to 0x40.
6. After S_DONE, drive rx_valid=1 for 10 cycles -> rx_ready stays 0, no imem_we, words_loaded unchanged.
